// File: rtl/notch_filter_sequencer.sv
// notch_filter_sequencer: time-multiplexed biquad notch sequencer with shadow coefficient bank
module notch_filter_sequencer #(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int ACC_W  = 50
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     x_in_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   y_out_o,
  output logic                 sat_o,
  input  logic                 cfg_we_i,
  input  logic [2:0]           cfg_addr_i,
  input  logic [COEF_W-1:0]    cfg_data_i,
  input  logic                 cfg_commit_i,
  input  logic                 clear_i,
  output logic                 busy_o
);
  localparam int YW = 2 * WIDTH;
  localparam int PW = YW + COEF_W;
  localparam logic signed [COEF_W-1:0] ONE  = COEF_W'(1 << FRAC);
  localparam logic signed [ACC_W-1:0]  HALF = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0]  YMAX = (ACC_W'(1) <<< (YW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  YMIN = -YMAX - ACC_W'(1);
  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;
  state_t state;
  logic [2:0] step;
  logic signed [WIDTH-1:0] xs, x1, x2;
  logic signed [YW-1:0] y1, y2, opnd, y_sat;
  logic signed [COEF_W-1:0] sh [5];
  logic signed [COEF_W-1:0] act [5];
  logic signed [COEF_W-1:0] sh_nx [5];
  logic signed [COEF_W-1:0] coef;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] acc, prod_ext, rnd;
  logic pend_commit, pend_clear, do_commit, do_clear, accept, hi, lo;
  always_comb begin
    sh_nx = sh;
    if (cfg_we_i && cfg_addr_i < 3'd5) sh_nx[cfg_addr_i] = cfg_data_i;
    coef = act[step];
    opnd = step == 3'd0 ? {xs, {WIDTH{1'b0}}} :
           step == 3'd1 ? {x1, {WIDTH{1'b0}}} :
           step == 3'd2 ? {x2, {WIDTH{1'b0}}} :
           step == 3'd3 ? y1 : y2;
    prod = coef * opnd;
    prod_ext = ACC_W'(prod);
    rnd = (acc + HALF) >>> FRAC;
    hi = rnd > YMAX;
    lo = rnd < YMIN;
    y_sat = hi ? YMAX[YW-1:0] : lo ? YMIN[YW-1:0] : rnd[YW-1:0];
    accept = state == IDLE && in_valid_i && in_ready_o;
    do_commit = state == IDLE && (cfg_commit_i || pend_commit);
    do_clear = state == IDLE && (clear_i || pend_clear);
    busy_o = state != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= IDLE;
      step <= '0;
      in_ready_o <= 1'b0;
      out_valid_o <= 1'b0;
      y_out_o <= '0;
      sat_o <= 1'b0;
      xs <= '0;
      x1 <= '0;
      x2 <= '0;
      y1 <= '0;
      y2 <= '0;
      acc <= '0;
      pend_commit <= 1'b0;
      pend_clear <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        sh[i] <= i == 0 ? ONE : '0;
        act[i] <= i == 0 ? ONE : '0;
      end
    end else begin
      sh <= sh_nx;
      if (do_commit) act <= sh_nx;
      pend_commit <= state != IDLE && (pend_commit || cfg_commit_i);
      pend_clear <= state != IDLE && (pend_clear || clear_i);
      case (state)
        IDLE: begin
          in_ready_o <= !accept;
          if (do_clear) begin
            x1 <= '0;
            x2 <= '0;
            y1 <= '0;
            y2 <= '0;
          end
          if (accept) begin
            xs <= x_in_i;
            acc <= '0;
            step <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= step >= 3'd3 ? acc - prod_ext : acc + prod_ext;
          step <= step == 3'd4 ? 3'd0 : step + 3'd1;
          if (step == 3'd4) state <= SCALE;
        end
        SCALE: begin
          y_out_o <= y_sat;
          sat_o <= hi || lo;
          out_valid_o <= 1'b1;
          x2 <= x1;
          x1 <= xs;
          y2 <= y1;
          y1 <= y_sat;
          state <= OUT;
        end
        default: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_notch_filter_sequencer.sv
// tb_notch_filter_sequencer: directed self-checking bench for notch_filter_sequencer
module tb_notch_filter_sequencer;
  logic clk_i = 1'b0;
  logic reset_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, sat_o;
  logic cfg_we_i, cfg_commit_i, clear_i, busy_o;
  logic [15:0] x_in_i, cfg_data_i;
  logic [31:0] y_out_o;
  logic [2:0] cfg_addr_i;
  int checks = 0;
  int errors = 0;
  always #5 clk_i = ~clk_i;
  notch_filter_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .x_in_i(x_in_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .y_out_o(y_out_o),
    .sat_o(sat_o), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_commit_i(cfg_commit_i), .clear_i(clear_i), .busy_o(busy_o)
  );
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input logic [2:0] a, input logic [15:0] d);
    cfg_we_i = 1'b1;
    cfg_addr_i = a;
    cfg_data_i = d;
    tick;
    cfg_we_i = 1'b0;
  endtask
  task automatic wait_ready;
    int n = 0;
    while (!in_ready_o && n < 20) begin
      tick;
      n++;
    end
    chk("ready_wait", in_ready_o, 1);
  endtask
  task automatic send(input logic [15:0] x, input logic [31:0] ey, input logic es);
    wait_ready;
    x_in_i = x;
    in_valid_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    cfg_we_i = 1'b0;
    cfg_commit_i = 1'b0;
    clear_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("mac_window", {out_valid_o, in_ready_o, busy_o}, 3'b001);
    end
    tick;
    chk("out_valid", out_valid_o, 1);
    chk("out_ready_low", in_ready_o, 0);
    chk("y_out", y_out_o, ey);
    chk("sat", sat_o, es);
    tick;
  endtask
  initial begin
    reset_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    cfg_we_i = 1'b0;
    cfg_commit_i = 1'b0;
    clear_i = 1'b0;
    x_in_i = '0;
    cfg_data_i = '0;
    cfg_addr_i = '0;
    tick;
    tick;
    chk("reset_flags", {in_ready_o, out_valid_o, sat_o, busy_o}, 4'b0000);
    chk("reset_y", y_out_o, 0);
    reset_i = 1'b1;
    tick;
    chk("ready_after_reset", in_ready_o, 1);
    send(16'd30, 32'd1966080, 1'b0);
    cfg(3'd0, 16'd0);
    cfg(3'd1, 16'd16384);
    cfg_commit_i = 1'b1;
    clear_i = 1'b1;
    send(16'd30, 32'd0, 1'b0);
    send(16'd20, 32'd1966080, 1'b0);
    cfg(3'd0, 16'd16384);
    cfg(3'd1, 16'd0);
    cfg_we_i = 1'b1;
    cfg_addr_i = 3'd3;
    cfg_data_i = -16'sd8192;
    cfg_commit_i = 1'b1;
    clear_i = 1'b1;
    send(16'd100, 32'd6553600, 1'b0);
    send(16'd0, 32'd3276800, 1'b0);
    send(16'd0, 32'd1638400, 1'b0);
    cfg(3'd0, 16'd32767);
    cfg(3'd3, -16'sd16384);
    cfg_commit_i = 1'b1;
    clear_i = 1'b1;
    send(16'd32767, 32'h7FFF_FFFF, 1'b1);
    send(16'd32767, 32'h7FFF_FFFF, 1'b1);
    cfg(3'd0, 16'd0);
    cfg_commit_i = 1'b1;
    send(16'd0, 32'h7FFF_FFFF, 1'b0);
    cfg(3'd0, 16'd32767);
    cfg(3'd3, 16'd0);
    cfg_commit_i = 1'b1;
    clear_i = 1'b1;
    send(16'h8000, 32'h8000_0000, 1'b1);
    cfg(3'd0, 16'd16384);
    cfg_commit_i = 1'b1;
    clear_i = 1'b1;
    tick;
    cfg_commit_i = 1'b0;
    clear_i = 1'b0;
    out_ready_i = 1'b0;
    wait_ready;
    x_in_i = 16'd10;
    in_valid_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    tick;
    cfg_we_i = 1'b1;
    cfg_addr_i = 3'd0;
    cfg_data_i = 16'd8192;
    cfg_commit_i = 1'b1;
    tick;
    cfg_commit_i = 1'b0;
    cfg_addr_i = 3'd5;
    cfg_data_i = 16'h1234;
    tick;
    cfg_we_i = 1'b0;
    tick;
    tick;
    tick;
    chk("hold_valid", out_valid_o, 1);
    chk("old_coef_y", y_out_o, 32'd655360);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_flags", {out_valid_o, in_ready_o, sat_o}, 3'b100);
      chk("hold_y", y_out_o, 32'd655360);
    end
    out_ready_i = 1'b1;
    tick;
    chk("release_flags", {out_valid_o, in_ready_o, busy_o}, 3'b010);
    send(16'd10, 32'd327680, 1'b0);
    wait_ready;
    x_in_i = 16'd30;
    in_valid_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    tick;
    tick;
    reset_i = 1'b0;
    tick;
    chk("abort_flags", {in_ready_o, out_valid_o, sat_o, busy_o}, 4'b0000);
    chk("abort_y", y_out_o, 0);
    reset_i = 1'b1;
    tick;
    chk("abort_ready", in_ready_o, 1);
    send(16'd30, 32'd1966080, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
